interboard_msg_queue: RTL and testbench

//   Receive-side message buffer downstream of InterboardCommunication_top. Captures each decoded

---
 rtl/interboard_msg_queue.sv | 102 ++++++++++
 tb/tb_interboard_msg_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/interboard_msg_queue.sv
// Receive-side FWFT message queue with fill level, sticky overflow and optional duplicate filter.
// Optional feature: define INTERBOARD_DUP_FILTER_EN to drop pushes equal to the last accepted message.
module interboard_msg_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          interboard_rst,
    input  logic          interboard_en,
    input  logic [2:0]    interboard_msg_type,
    input  logic [4:0]    interboard_number,
    input  logic          pop,
    input  logic          ovf_clr,
    output logic          out_valid,
    output logic [2:0]    out_msg_type,
    output logic [4:0]    out_number,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          overflow,
    output logic          dup_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    wr_data;
    logic          dup_hit;
    logic          push_ok;
    logic          pop_ok;
    logic          lost;

    assign wr_data = {interboard_msg_type, interboard_number};

`ifdef INTERBOARD_DUP_FILTER_EN
    logic [7:0] last_accepted;
    logic       last_vld;

    assign dup_hit = interboard_en && last_vld && (last_accepted == wr_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_accepted <= '0;
            last_vld      <= 1'b0;
        end else if (interboard_rst) begin
            last_accepted <= '0;
            last_vld      <= 1'b0;
        end else if (push_ok) begin
            last_accepted <= wr_data;
            last_vld      <= 1'b1;
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    assign out_valid = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop_ok    = pop && out_valid;
    // A pop on a full queue frees the slot the same cycle, so push may proceed.
    assign push_ok   = interboard_en && !dup_hit && (!full || pop);
    assign lost      = interboard_en && !dup_hit && full && !pop;

    assign out_msg_type = out_valid ? mem[rd_ptr][7:5] : '0;
    assign out_number   = out_valid ? mem[rd_ptr][4:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst && !interboard_rst && push_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dup_drop <= 1'b0;
        end else if (interboard_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dup_drop <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)
                count <= count + CW'(1);
            else if (pop_ok && !push_ok)
                count <= count - CW'(1);
            if (lost)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            dup_drop <= dup_hit;
        end
    end
endmodule

// File: tb/tb_interboard_msg_queue.sv
// Directed bench for interboard_msg_queue with a queue scoreboard; honours INTERBOARD_DUP_FILTER_EN.
module tb_interboard_msg_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          interboard_rst = 1'b0;
    logic          interboard_en = 1'b0;
    logic [2:0]    interboard_msg_type = '0;
    logic [4:0]    interboard_number = '0;
    logic          pop = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          out_valid;
    logic [2:0]    out_msg_type;
    logic [4:0]    out_number;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;
    logic          dup_drop;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic       ovf_m = 1'b0;
    logic       dup_m = 1'b0;
    logic [7:0] last_m = '0;
    logic       lastv_m = 1'b0;

    interboard_msg_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
        .interboard_en(interboard_en), .interboard_msg_type(interboard_msg_type),
        .interboard_number(interboard_number), .pop(pop), .ovf_clr(ovf_clr),
        .out_valid(out_valid), .out_msg_type(out_msg_type), .out_number(out_number),
        .count(count), .full(full), .overflow(overflow), .dup_drop(dup_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        chk({tag, ".count"}, 32'(count), 32'(exp_q.size()));
        chk({tag, ".full"}, 32'(full), 32'(exp_q.size() == DEPTH));
        chk({tag, ".valid"}, 32'(out_valid), 32'(exp_q.size() > 0));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
        chk({tag, ".dup"}, 32'(dup_drop), 32'(dup_m));
        chk({tag, ".head"}, 32'({out_msg_type, out_number}), 32'(head));
    endtask

    // One clock of stimulus; the model is advanced alongside and checked after the edge.
    task automatic step(input string tag, input logic en, input logic [2:0] t, input logic [4:0] n,
                        input logic p, input logic clr, input logic ibrst);
        logic dup, acc, lost, full_m;
        if (p && exp_q.size() > 0)
            chk({tag, ".pop_head"}, 32'({out_msg_type, out_number}), 32'(exp_q[0]));
        interboard_en = en;
        interboard_msg_type = t;
        interboard_number = n;
        pop = p;
        ovf_clr = clr;
        interboard_rst = ibrst;
        if (ibrst) begin
            exp_q.delete();
            ovf_m = 1'b0;
            dup_m = 1'b0;
            lastv_m = 1'b0;
        end else begin
`ifdef INTERBOARD_DUP_FILTER_EN
            dup = en && lastv_m && (last_m == {t, n});
`else
            dup = 1'b0;
`endif
            full_m = (exp_q.size() == DEPTH);
            acc = en && !dup && (!full_m || p);
            lost = en && !dup && full_m && !p;
            if (p && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back({t, n});
                last_m = {t, n};
                lastv_m = 1'b1;
            end
            if (lost)
                ovf_m = 1'b1;
            else if (clr)
                ovf_m = 1'b0;
            dup_m = dup;
        end
        @(posedge clk);
        #1;
        interboard_en = 1'b0;
        pop = 1'b0;
        ovf_clr = 1'b0;
        interboard_rst = 1'b0;
        check_state(tag);
    endtask

    initial begin
        // Reset
        #2;
        check_state("rst_async");
        #10 rst = 1'b0;
        @(posedge clk);
        #1;
        check_state("rst");
        chk("rst_outs", 32'({out_valid, out_msg_type, out_number, full, overflow, dup_drop}), 32'h0);

        // Ordered push then drain
        step("p1", 1, 3'd3, 5'd17, 0, 0, 0);
        step("p2", 1, 3'd1, 5'd5, 0, 0, 0);
        step("p3", 1, 3'd2, 5'd9, 0, 0, 0);
        chk("three.count", 32'(count), 32'd3);
        chk("three.head", 32'({out_msg_type, out_number}), 32'({3'd3, 5'd17}));
        step("pop1", 0, 3'd0, 5'd0, 1, 0, 0);
        chk("pop1.head", 32'({out_msg_type, out_number}), 32'({3'd1, 5'd5}));
        step("pop2", 0, 3'd0, 5'd0, 1, 0, 0);
        chk("pop2.head", 32'({out_msg_type, out_number}), 32'({3'd2, 5'd9}));
        step("pop3", 0, 3'd0, 5'd0, 1, 0, 0);
        chk("drained.valid", 32'(out_valid), 32'd0);
        step("pop_empty", 0, 3'd0, 5'd0, 1, 0, 0);

        // Fill to full, overflow, clear
        step("f1", 1, 3'd1, 5'd1, 0, 0, 0);
        step("f2", 1, 3'd1, 5'd2, 0, 0, 0);
        step("f3", 1, 3'd1, 5'd3, 0, 0, 0);
        step("f4", 1, 3'd1, 5'd4, 0, 0, 0);
        chk("f4.full", 32'(full), 32'd1);
        step("f5", 1, 3'd1, 5'd6, 0, 0, 0);
        chk("f5.ovf", 32'(overflow), 32'd1);
        chk("f5.head", 32'({out_msg_type, out_number}), 32'({3'd1, 5'd1}));
        step("ovf_clr", 0, 3'd0, 5'd0, 0, 1, 0);
        chk("ovf_clr.ovf", 32'(overflow), 32'd0);

        // Full push+pop, drain to tail, empty push+pop
        step("fullpp", 1, 3'd4, 5'd30, 1, 0, 0);
        chk("fullpp.count", 32'(count), 32'd4);
        chk("fullpp.head", 32'({out_msg_type, out_number}), 32'({3'd1, 5'd2}));
        step("d1", 0, 3'd0, 5'd0, 1, 0, 0);
        step("d2", 0, 3'd0, 5'd0, 1, 0, 0);
        step("d3", 0, 3'd0, 5'd0, 1, 0, 0);
        chk("tail.head", 32'({out_msg_type, out_number}), 32'({3'd4, 5'd30}));
        step("d4", 0, 3'd0, 5'd0, 1, 0, 0);
        step("emptypp", 1, 3'd5, 5'd11, 1, 0, 0);
        chk("emptypp.count", 32'(count), 32'd1);

        // Synchronous clear beats concurrent push
        step("c2", 1, 3'd6, 5'd12, 0, 0, 0);
        chk("c2.count", 32'(count), 32'd2);
        step("ibrst", 1, 3'd7, 5'd13, 1, 0, 1);
        chk("ibrst.count", 32'(count), 32'd0);
        chk("ibrst.valid", 32'(out_valid), 32'd0);

        // Overflow set wins over ovf_clr
        step("g1", 1, 3'd1, 5'd1, 0, 0, 0);
        step("g2", 1, 3'd1, 5'd2, 0, 0, 0);
        step("g3", 1, 3'd1, 5'd3, 0, 0, 0);
        step("g4", 1, 3'd1, 5'd4, 0, 0, 0);
        step("setwins", 1, 3'd2, 5'd2, 0, 1, 0);
        chk("setwins.ovf", 32'(overflow), 32'd1);
        step("ibrst2", 0, 3'd0, 5'd0, 0, 0, 1);

        // Duplicate handling
        step("dup_a", 1, 3'd2, 5'd7, 0, 0, 0);
        step("dup_b", 1, 3'd2, 5'd7, 0, 0, 0);
`ifdef INTERBOARD_DUP_FILTER_EN
        chk("dup_b.count", 32'(count), 32'd1);
        chk("dup_b.pulse", 32'(dup_drop), 32'd1);
        step("dup_c", 1, 3'd2, 5'd8, 0, 0, 0);
        step("dup_d", 1, 3'd2, 5'd7, 0, 0, 0);
        chk("dup_d.count", 32'(count), 32'd3);
`else
        chk("dup_b.count", 32'(count), 32'd2);
        chk("dup_b.pulse", 32'(dup_drop), 32'd0);
`endif

        // Asynchronous reset mid-run
        #3 rst = 1'b1;
        #1;
        exp_q.delete();
        ovf_m = 1'b0;
        dup_m = 1'b0;
        lastv_m = 1'b0;
        chk("async.count", 32'(count), 32'd0);
        check_state("async");
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
